// File: rtl/alu_pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipeline_pkg
// Description : Shared types for the back-pressured ALU pipeline. Holds the
//               ALU function select encoding and the select width.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pipeline_pkg;

    localparam int c_SEL_W = 3;

    typedef enum logic [c_SEL_W-1:0] {
        c_OP_ADD  = 3'd0,
        c_OP_SUB  = 3'd1,
        c_OP_AND  = 3'd2,
        c_OP_OR   = 3'd3,
        c_OP_XOR  = 3'd4,
        c_OP_SLL  = 3'd5,
        c_OP_SRL  = 3'd6,
        c_OP_PASS = 3'd7
    } alu_op_e;

endpackage : alu_pipeline_pkg
`default_nettype wire

// File: rtl/alu_pipeline_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Combinational 8-function ALU with sign and zero flags.
// Ports       : op1, op2 - operands (DWIDTH)
//               sel      - function select (alu_op_e encoding)
//               res      - result (DWIDTH)
//               neg      - result MSB
//               zero     - result is all zeros
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_pipeline_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [DWIDTH-1:0]  op1,
    input  logic [DWIDTH-1:0]  op2,
    input  logic [c_SEL_W-1:0] sel,
    output logic [DWIDTH-1:0]  res,
    output logic               neg,
    output logic               zero
);

    localparam int c_SH_W = $clog2(DWIDTH);

    // Only the low log2(DWIDTH) bits of op2 form the shift amount; the
    // upper bits are ignored so shifts never exceed the word width.
    logic [c_SH_W-1:0] w_shamt;
    logic [DWIDTH-1:0] w_res;

    assign w_shamt = op2[c_SH_W-1:0];

    always_comb begin
        w_res = '0;
        case (alu_op_e'(sel))
            c_OP_ADD:  w_res = op1 + op2;
            c_OP_SUB:  w_res = op1 - op2;
            c_OP_AND:  w_res = op1 & op2;
            c_OP_OR:   w_res = op1 | op2;
            c_OP_XOR:  w_res = op1 ^ op2;
            c_OP_SLL:  w_res = op1 << w_shamt;
            c_OP_SRL:  w_res = op1 >> w_shamt;
            c_OP_PASS: w_res = op1;
            default:   w_res = op1;
        endcase
    end

    assign res  = w_res;
    assign neg  = w_res[DWIDTH-1];
    assign zero = (w_res == '0);

endmodule : alu_core
`default_nettype wire

// File: rtl/alu_pipeline.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipeline
// Description : Valid/ready ALU pipeline. The ALU evaluates ahead of stage 0;
//               result and flags then travel through STAGES register stages
//               with collapsing bubbles and a combinational ready chain.
// Ports       : clk, rst         - clock, synchronous active-low reset
//               in_valid_i/in_ready_o   - input handshake
//               op1_i, op2_i, sel_i     - operands and function select
//               out_valid_o/out_ready_i - output handshake
//               res_o, neg_o, zero_o    - result and its flags
//               occ_o             - number of ops in flight
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pipeline
    import alu_pipeline_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int STAGES = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [DWIDTH-1:0]           op1_i,
    input  logic [DWIDTH-1:0]           op2_i,
    input  logic [c_SEL_W-1:0]          sel_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [DWIDTH-1:0]           res_o,
    output logic                        neg_o,
    output logic                        zero_o,
    output logic [$clog2(STAGES+1)-1:0] occ_o
);

    localparam int c_OCC_W = $clog2(STAGES + 1);
    localparam int c_LAST  = STAGES - 1;

    typedef struct packed {
        logic              valid;
        logic              neg;
        logic              zero;
        logic [DWIDTH-1:0] res;
    } stage_t;

    logic [DWIDTH-1:0]  w_alu_res;
    logic               w_alu_neg;
    logic               w_alu_zero;
    stage_t             w_stage_in;
    stage_t             r_stage [STAGES];
    logic [STAGES-1:0]  w_load;
    logic               w_in_xfer;
    logic               w_out_xfer;
    logic [c_OCC_W-1:0] r_occ;

    alu_core #(
        .DWIDTH (DWIDTH)
    ) u_alu_core (
        .op1  (op1_i),
        .op2  (op2_i),
        .sel  (sel_i),
        .res  (w_alu_res),
        .neg  (w_alu_neg),
        .zero (w_alu_zero)
    );

    // Stage 0 always samples the ALU when it loads; the valid bit decides
    // whether the captured value is a real op or a bubble.
    assign w_stage_in = {in_valid_i, w_alu_neg, w_alu_zero, w_alu_res};

    // Ready chain, walked from the output back toward the input. A stage may
    // load if it is empty or its successor is loading, which is what lets
    // interior bubbles collapse while the output is stalled.
    always_comb begin
        w_load         = '0;
        w_load[c_LAST] = !r_stage[c_LAST].valid || out_ready_i;
        for (int k = STAGES - 2; k >= 0; k--) begin
            w_load[k] = !r_stage[k].valid || w_load[k+1];
        end
    end

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            if (k == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (!rst) begin
                        r_stage[k] <= '0;
                    end else if (w_load[k]) begin
                        r_stage[k] <= w_stage_in;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (!rst) begin
                        r_stage[k] <= '0;
                    end else if (w_load[k]) begin
                        r_stage[k] <= r_stage[k-1];
                    end
                end
            end
        end
    endgenerate

    assign w_in_xfer  = in_valid_i && w_load[0];
    assign w_out_xfer = r_stage[c_LAST].valid && out_ready_i;

    // Occupancy tracks transfers rather than summing valid bits, keeping the
    // count off the ready chain's combinational path.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_occ <= '0;
        end else if (w_in_xfer && !w_out_xfer) begin
            r_occ <= r_occ + c_OCC_W'(1);
        end else if (!w_in_xfer && w_out_xfer) begin
            r_occ <= r_occ - c_OCC_W'(1);
        end
    end

    assign in_ready_o  = w_load[0];
    assign out_valid_o = r_stage[c_LAST].valid;
    assign res_o       = r_stage[c_LAST].res;
    assign neg_o       = r_stage[c_LAST].neg;
    assign zero_o      = r_stage[c_LAST].zero;
    assign occ_o       = r_occ;

endmodule : alu_pipeline
`default_nettype wire

// File: tb/tb_alu_pipeline.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_pipeline
// Description : Self-checking bench for alu_pipeline. Main instance uses
//               DWIDTH=32/STAGES=3; two further instances cover STAGES=1
//               and DWIDTH=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipeline;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance
    logic        rst, in_valid, out_ready;
    logic [31:0] op1, op2;
    logic [2:0]  sel;
    logic        in_ready, out_valid, neg, zero;
    logic [31:0] res;
    logic [1:0]  occ;

    // Variant instances share one stimulus set
    logic        v_rst, v_in_valid, v_out_ready;
    logic [31:0] v_op1, v_op2;
    logic [2:0]  v_sel;
    logic        v1_in_ready, v1_out_valid, v1_neg, v1_zero;
    logic [31:0] v1_res;
    logic [0:0]  v1_occ;
    logic        v2_in_ready, v2_out_valid, v2_neg, v2_zero;
    logic [7:0]  v2_res;
    logic [1:0]  v2_occ;

    alu_pipeline #(.DWIDTH(32), .STAGES(3)) u_dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .op1_i(op1), .op2_i(op2), .sel_i(sel), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .res_o(res), .neg_o(neg), .zero_o(zero),
        .occ_o(occ)
    );

    alu_pipeline #(.DWIDTH(32), .STAGES(1)) u_dut_s1 (
        .clk(clk), .rst(v_rst), .in_valid_i(v_in_valid), .in_ready_o(v1_in_ready),
        .op1_i(v_op1), .op2_i(v_op2), .sel_i(v_sel), .out_valid_o(v1_out_valid),
        .out_ready_i(v_out_ready), .res_o(v1_res), .neg_o(v1_neg), .zero_o(v1_zero),
        .occ_o(v1_occ)
    );

    alu_pipeline #(.DWIDTH(8), .STAGES(3)) u_dut_w8 (
        .clk(clk), .rst(v_rst), .in_valid_i(v_in_valid), .in_ready_o(v2_in_ready),
        .op1_i(v_op1[7:0]), .op2_i(v_op2[7:0]), .sel_i(v_sel), .out_valid_o(v2_out_valid),
        .out_ready_i(v_out_ready), .res_o(v2_res), .neg_o(v2_neg), .zero_o(v2_zero),
        .occ_o(v2_occ)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference ALU: plain wide arithmetic, masked down to the word width.
    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] s, input int w);
        longint unsigned m, ua, ub, r, sh;
        m  = (64'd1 << w) - 64'd1;
        ua = 64'(a) & m;
        ub = 64'(b) & m;
        sh = ub % 64'(w);
        case (s)
            3'd0:    r = ua + ub;
            3'd1:    r = ua - ub;
            3'd2:    r = ua & ub;
            3'd3:    r = ua | ub;
            3'd4:    r = ua ^ ub;
            3'd5:    r = ua << sh;
            3'd6:    r = ua >> sh;
            default: r = ua;
        endcase
        return 32'(r & m);
    endfunction

    // Scoreboard for the main instance: an op accepted on edge n can be at
    // the output after edge n+STAGES-1, and never before the edge on which
    // its predecessor left.
    typedef struct {
        logic [31:0] r;
        int          n;
    } ent_t;

    ent_t        q[$];
    logic [31:0] got_q[$];
    int          edge_idx  = 0;
    int          last_dep  = -1;
    int          in_cnt    = 0;
    int          out_cnt   = 0;
    logic        last_in_x = 1'b0;

    task automatic cycle();
        logic        in_x, out_x, exp_ov;
        logic [31:0] res_now, exp_r;
        int          ready_at;
        #1;
        exp_ov = 1'b0;
        if (q.size() > 0) begin
            ready_at = q[0].n + 2;
            if (last_dep > ready_at) ready_at = last_dep;
            exp_ov = ((edge_idx - 1) >= ready_at);
        end
        if (rst) chk("sb_in_ready", in_ready, (q.size() < 3) || out_ready);
        chk("sb_occ", occ, q.size());
        chk("sb_out_valid", out_valid, exp_ov);
        if (exp_ov) begin
            exp_r = q[0].r;
            chk("sb_res", res, exp_r);
            chk("sb_neg", neg, exp_r[31]);
            chk("sb_zero", zero, exp_r == 32'd0);
        end
        in_x    = in_valid && in_ready;
        out_x   = out_valid && out_ready;
        res_now = res;
        exp_r   = ref_alu(op1, op2, sel, 32);
        @(posedge clk);
        last_in_x = 1'b0;
        if (!rst) begin
            q.delete();
        end else begin
            if (out_x) begin
                got_q.push_back(res_now);
                if (q.size() > 0) void'(q.pop_front());
                last_dep = edge_idx;
                out_cnt++;
            end
            if (in_x) begin
                q.push_back('{r: exp_r, n: edge_idx});
                in_cnt++;
                last_in_x = 1'b1;
            end
        end
        edge_idx++;
        @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  s;
        logic [31:0] er;
        logic        en;
        logic        ez;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int nxt, i0, o0;

        vecs[0]  = '{32'd5,          32'd7,          3'd0, 32'd12,         1'b0, 1'b0};
        vecs[1]  = '{32'd3,          32'd5,          3'd1, 32'hFFFF_FFFE,  1'b1, 1'b0};
        vecs[2]  = '{32'd9,          32'd9,          3'd1, 32'd0,          1'b0, 1'b1};
        vecs[3]  = '{32'hF0F0_00FF,  32'h0000_0004,  3'd2, 32'h0000_0004,  1'b0, 1'b0};
        vecs[4]  = '{32'hF0F0_00FF,  32'h0000_0004,  3'd3, 32'hF0F0_00FF,  1'b1, 1'b0};
        vecs[5]  = '{32'hF0F0_00FF,  32'h0000_0004,  3'd4, 32'hF0F0_00FB,  1'b1, 1'b0};
        vecs[6]  = '{32'hF0F0_00FF,  32'h0000_0004,  3'd5, 32'h0F00_0FF0,  1'b0, 1'b0};
        vecs[7]  = '{32'hF0F0_00FF,  32'h0000_0004,  3'd6, 32'h0F0F_000F,  1'b0, 1'b0};
        vecs[8]  = '{32'hF0F0_00FF,  32'h0000_0004,  3'd7, 32'hF0F0_00FF,  1'b1, 1'b0};
        vecs[9]  = '{32'hFFFF_FFFF,  32'd1,          3'd0, 32'd0,          1'b0, 1'b1};
        vecs[10] = '{32'h0000_0001,  32'h0000_0021,  3'd5, 32'h0000_0002,  1'b0, 1'b0};

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op1 = '0; op2 = '0; sel = '0;
        v_rst = 1'b0; v_in_valid = 1'b0; v_out_ready = 1'b1;
        v_op1 = '0; v_op2 = '0; v_sel = '0;

        @(negedge clk);
        repeat (2) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occ", occ, 0);
        chk("rst_res", res, 0);

        // Single ops: exact three-cycle latency
        foreach (vecs[i]) begin
            op1 = vecs[i].a; op2 = vecs[i].b; sel = vecs[i].s;
            in_valid = 1'b1;
            cycle();
            in_valid = 1'b0;
            cycle();
            chk("vec_early", out_valid, 0);
            cycle();
            chk("vec_valid", out_valid, 1);
            chk("vec_res", res, vecs[i].er);
            chk("vec_neg", neg, vecs[i].en);
            chk("vec_zero", zero, vecs[i].ez);
            cycle();
        end

        // Backpressure: only three accepted while stalled, then in-order drain
        out_ready = 1'b0; in_valid = 1'b1; sel = 3'd0; op2 = 32'd0;
        nxt = 1; op1 = 32'd1;
        for (int c = 0; c < 8; c++) begin
            cycle();
            if (last_in_x) begin nxt++; op1 = 32'(nxt); end
        end
        #1;
        chk("bp_accepts", nxt - 1, 3);
        chk("bp_occ", occ, 3);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_res_stable", res, 1);
        got_q.delete();
        out_ready = 1'b1;
        for (int c = 0; c < 40 && got_q.size() < 6; c++) begin
            cycle();
            if (last_in_x) begin
                nxt++;
                if (nxt > 6) in_valid = 1'b0;
                else op1 = 32'(nxt);
            end
        end
        chk("bp_count", got_q.size(), 6);
        for (int i = 0; i < 6 && i < got_q.size(); i++) chk("bp_order", got_q[i], i + 1);

        // Full pipeline with simultaneous in/out transfers
        out_ready = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 10 && occ != 2'd3; c++) begin
            op1 = $urandom; op2 = $urandom; sel = 3'($urandom_range(0, 7));
            cycle();
        end
        chk("full_fill_occ", occ, 3);
        out_ready = 1'b1;
        i0 = in_cnt; o0 = out_cnt;
        repeat (10) begin
            op1 = $urandom; op2 = $urandom; sel = 3'($urandom_range(0, 7));
            cycle();
        end
        chk("full_in_xfers", in_cnt - i0, 10);
        chk("full_out_xfers", out_cnt - o0, 10);
        chk("full_occ", occ, 3);
        in_valid = 1'b0;
        repeat (4) cycle();
        chk("full_drain_occ", occ, 0);

        // Bubble collapse under a stalled output
        out_ready = 1'b0; in_valid = 1'b1; sel = 3'd7; op1 = 32'hA;
        cycle();
        in_valid = 1'b0;
        cycle(); cycle();
        in_valid = 1'b1; op1 = 32'hB;
        cycle();
        in_valid = 1'b0;
        chk("bub_occ", occ, 2);
        chk("bub_out_valid", out_valid, 1);
        chk("bub_res", res, 32'hA);
        out_ready = 1'b1;
        repeat (4) cycle();
        chk("bub_drain_occ", occ, 0);

        // Reset while full, with an op presented during reset
        out_ready = 1'b0; in_valid = 1'b1; sel = 3'd0; op1 = 32'd7; op2 = 32'd8;
        repeat (3) cycle();
        chk("mrst_pre_occ", occ, 3);
        rst = 1'b0;
        cycle();
        rst = 1'b1; in_valid = 1'b0;
        #1;
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_res", res, 0);
        chk("mrst_occ", occ, 0);
        chk("mrst_in_ready", in_ready, 1);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            op1 = $urandom; op2 = $urandom; sel = 3'($urandom_range(0, 7));
            rst = ($urandom_range(0, 99) != 0);
            cycle();
        end
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) cycle();
        chk("rand_drain_occ", occ, 0);

        // Variants: STAGES=1 and DWIDTH=8
        v_rst = 1'b0;
        cycle();
        v_rst = 1'b1;
        #1;
        chk("s1_rst_in_ready", v1_in_ready, 1);
        chk("s1_rst_out_valid", v1_out_valid, 0);
        chk("s1_rst_occ", v1_occ, 0);
        chk("w8_rst_in_ready", v2_in_ready, 1);
        chk("w8_rst_out_valid", v2_out_valid, 0);
        chk("w8_rst_occ", v2_occ, 0);

        v_out_ready = 1'b0; v_in_valid = 1'b1; v_sel = 3'd1; v_op1 = 32'd5; v_op2 = 32'd7;
        repeat (4) cycle();
        #1;
        chk("s1_full_occ", v1_occ, 1);
        chk("s1_full_in_ready", v1_in_ready, 0);
        chk("s1_full_out_valid", v1_out_valid, 1);
        chk("s1_full_res", v1_res, 32'hFFFF_FFFE);
        chk("s1_full_neg", v1_neg, 1);
        chk("w8_full_occ", v2_occ, 3);
        chk("w8_full_in_ready", v2_in_ready, 0);
        chk("w8_full_out_valid", v2_out_valid, 1);
        chk("w8_full_res", v2_res, 8'hFE);
        chk("w8_full_neg", v2_neg, 1);

        v_rst = 1'b0;
        cycle();
        v_rst = 1'b1; v_in_valid = 1'b0;
        #1;
        chk("s1_mrst_out_valid", v1_out_valid, 0);
        chk("s1_mrst_res", v1_res, 0);
        chk("s1_mrst_occ", v1_occ, 0);
        chk("s1_mrst_in_ready", v1_in_ready, 1);
        chk("w8_mrst_out_valid", v2_out_valid, 0);
        chk("w8_mrst_res", v2_res, 0);
        chk("w8_mrst_occ", v2_occ, 0);
        chk("w8_mrst_in_ready", v2_in_ready, 1);

        v_out_ready = 1'b1; v_in_valid = 1'b1; v_sel = 3'd5; v_op1 = 32'd1; v_op2 = 32'd9;
        cycle();
        v_in_valid = 1'b0;
        #1;
        chk("s1_lat_valid", v1_out_valid, 1);
        chk("s1_lat_res", v1_res, 32'h0000_0200);
        chk("w8_lat_early", v2_out_valid, 0);
        cycle(); cycle();
        chk("w8_lat_valid", v2_out_valid, 1);
        chk("w8_lat_res", v2_res, 8'h02);
        chk("w8_lat_zero", v2_zero, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_alu_pipeline
`default_nettype wire
